wb_mux_2: RTL and testbench

Wishbone single-master to two-slave demultiplexer. It decodes each strobe's address against two base/mask windows and routes the beat to the matching slave. It terminates unmapped accesses with an error and aborts hung accesses with a bus-timeout error. It sits downstream of the port arbiters, between a shared master bus and the peripheral slaves.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_mux_2_if.sv | 28 ++
 rtl/wb_timeout_cnt.sv | 37 +++
 rtl/wb_mux_2.sv | 136 +++++++++++++
 tb/tb_wb_mux_2.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared Wishbone interconnect definitions: FSM encoding and
//               base/mask address decode.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_active = 2'd1;
    localparam logic [1:0] c_st_decerr = 2'd2;

    // Addresses are zero-extended to 64 bits so one function serves any width.
    function automatic logic wb_match(input logic [63:0] adr,
                                      input logic [63:0] base,
                                      input logic [63:0] mask);
        return (mask != 64'd0) && ((adr & mask) == (base & mask));
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mux_2_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_mux_2_if
// Description : Wishbone classic bus bundle with master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_mux_2_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic                    we;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    stb;
    logic                    cyc;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (output adr, dat_w, we, sel, stb, cyc,
                    input  dat_r, ack, err, rty);
    modport slave  (input  adr, dat_w, we, sel, stb, cyc,
                    output dat_r, ack, err, rty);
endinterface
`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : wb_timeout_cnt
// Description : Saturating bus-timeout counter with clear, enable and expire.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout_cnt #(
    parameter int TIMEOUT   = 256,
    parameter int CNT_WIDTH = 16
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  i_clr,
    input  wire  i_en,
    output logic o_expire
);
    localparam bit                   c_enabled = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] c_limit   = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_WIDTH-1:0] r_count;

    // Expiry is decided in the same cycle the limit is reached so the caller can
    // cut the beat without an extra cycle of slave strobe.
    assign o_expire = c_enabled && i_en && (r_count == c_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr || o_expire) begin
            r_count <= '0;
        end else if (i_en && (r_count != {CNT_WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_mux_2.sv
`default_nettype none
// ============================================================================
// Module      : wb_mux_2
// Description : Wishbone 1-master to 2-slave demux with address decode,
//               decode-error termination and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mux_2
    import wb_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    SELECT_WIDTH = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] WBS0_ADDR    = '0,
    parameter logic [ADDR_WIDTH-1:0] WBS0_MASK    = '0,
    parameter logic [ADDR_WIDTH-1:0] WBS1_ADDR    = '0,
    parameter logic [ADDR_WIDTH-1:0] WBS1_MASK    = '0,
    parameter int                    TIMEOUT      = 256,
    parameter int                    CNT_WIDTH    = 16
) (
    input  wire         clk,
    input  wire         rst_n,
    wb_mux_2_if.slave   wbm,
    wb_mux_2_if.master  wbs0,
    wb_mux_2_if.master  wbs1,
    output logic        decerr_o,
    output logic        timeout_o
);
    logic [1:0]            r_state;
    logic [1:0]            r_sel;
    logic                  w_hit0;
    logic                  w_hit1;
    logic                  w_active;
    logic                  w_live;
    logic                  w_term;
    logic                  w_expire;
    logic                  w_ack;
    logic                  w_err;
    logic                  w_rty;
    logic [DATA_WIDTH-1:0] w_dat;

    assign w_hit0 = wb_match(64'(wbm.adr), 64'(WBS0_ADDR), 64'(WBS0_MASK));
    assign w_hit1 = wb_match(64'(wbm.adr), 64'(WBS1_ADDR), 64'(WBS1_MASK));

    assign w_active = (r_state == c_st_active);
    // A dropped master cycle aborts the beat combinationally.
    assign w_live   = w_active && wbm.cyc;

    always_comb begin
        w_ack = 1'b0;
        w_err = 1'b0;
        w_rty = 1'b0;
        w_dat = '0;
        if (r_sel[0]) begin
            w_ack = wbs0.ack;
            w_err = wbs0.err;
            w_rty = wbs0.rty;
            w_dat = wbs0.dat_r;
        end else if (r_sel[1]) begin
            w_ack = wbs1.ack;
            w_err = wbs1.err;
            w_rty = wbs1.rty;
            w_dat = wbs1.dat_r;
        end
    end

    assign w_term = w_live && (w_ack || w_err || w_rty);

    wb_timeout_cnt #(
        .TIMEOUT   (TIMEOUT),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (!w_live),
        .i_en     (w_live && !w_term),
        .o_expire (w_expire)
    );

    assign wbs0.adr   = wbm.adr;
    assign wbs0.dat_w = wbm.dat_w;
    assign wbs0.we    = wbm.we;
    assign wbs0.sel   = wbm.sel;
    assign wbs0.cyc   = w_live && r_sel[0] && !w_expire;
    assign wbs0.stb   = w_live && wbm.stb && r_sel[0] && !w_expire;

    assign wbs1.adr   = wbm.adr;
    assign wbs1.dat_w = wbm.dat_w;
    assign wbs1.we    = wbm.we;
    assign wbs1.sel   = wbm.sel;
    assign wbs1.cyc   = w_live && r_sel[1] && !w_expire;
    assign wbs1.stb   = w_live && wbm.stb && r_sel[1] && !w_expire;

    assign wbm.dat_r  = w_active ? w_dat : '0;
    assign wbm.ack    = w_live && w_ack;
    assign wbm.rty    = w_live && w_rty;
    assign wbm.err    = (w_live && w_err) || (r_state == c_st_decerr) || w_expire;
    assign decerr_o   = (r_state == c_st_decerr);
    assign timeout_o  = w_expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_sel   <= 2'b00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (wbm.cyc && wbm.stb) begin
                        // Slave 0 takes priority when windows overlap.
                        if (w_hit0) begin
                            r_sel   <= 2'b01;
                            r_state <= c_st_active;
                        end else if (w_hit1) begin
                            r_sel   <= 2'b10;
                            r_state <= c_st_active;
                        end else begin
                            r_state <= c_st_decerr;
                        end
                    end
                end
                c_st_active: begin
                    if (!wbm.cyc || w_term || w_expire) begin
                        r_state <= c_st_idle;
                        r_sel   <= 2'b00;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_sel   <= 2'b00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_mux_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_mux_2
// Description : Directed scoreboard bench for the wb_mux_2 demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_mux_2;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic        decerr;
        logic        tmo;
        logic [31:0] dat;
    } exp_t;

    logic clk;
    logic rst_n;
    logic decerr_o;
    logic timeout_o;
    int   n_vec;
    int   n_err;
    exp_t sb_q[$];
    exp_t mon_act;

    wb_mux_2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_bus ();
    wb_mux_2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0_bus ();
    wb_mux_2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s1_bus ();

    wb_mux_2 #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .WBS0_ADDR  (32'h0000_0000),
        .WBS0_MASK  (32'hFFFF_0000),
        .WBS1_ADDR  (32'h0001_0000),
        .WBS1_MASK  (32'hFFFF_0000),
        .TIMEOUT    (8),
        .CNT_WIDTH  (16)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbm       (m_bus),
        .wbs0      (s0_bus),
        .wbs1      (s1_bus),
        .decerr_o  (decerr_o),
        .timeout_o (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic ack, input logic err, input logic dec,
                                input logic tmo, input logic [31:0] dat);
        exp_t e;
        e.ack    = ack;
        e.err    = err;
        e.rty    = 1'b0;
        e.decerr = dec;
        e.tmo    = tmo;
        e.dat    = dat;
        return e;
    endfunction

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic master_start(input logic [31:0] adr, input logic we, input logic [31:0] dat);
        m_bus.adr   = adr;
        m_bus.we    = we;
        m_bus.dat_w = dat;
        m_bus.sel   = 4'hF;
        m_bus.cyc   = 1'b1;
        m_bus.stb   = 1'b1;
    endtask

    task automatic master_idle();
        m_bus.cyc = 1'b0;
        m_bus.stb = 1'b0;
        m_bus.we  = 1'b0;
    endtask

    // Monitor: every termination seen by the master is matched against the queue.
    always @(negedge clk) begin
        if (rst_n && (m_bus.ack || m_bus.err || m_bus.rty)) begin
            mon_act = mk(m_bus.ack, m_bus.err, decerr_o, timeout_o, m_bus.dat_r);
            mon_act.rty = m_bus.rty;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_term: got %h expected no termination", mon_act);
            end else begin
                check("scoreboard_term", 64'(mon_act), 64'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        master_start(32'h0000_0010, 1'b0, 32'h0);
        {s0_bus.ack, s0_bus.err, s0_bus.rty} = 3'b000;
        {s1_bus.ack, s1_bus.err, s1_bus.rty} = 3'b000;
        s0_bus.dat_r = 32'h0;
        s1_bus.dat_r = 32'h0;

        // Reset state, with the master already requesting.
        next();
        check("rst_slave_cyc", {s0_bus.cyc, s1_bus.cyc, s0_bus.stb, s1_bus.stb}, 0);
        check("rst_master_term", {m_bus.ack, m_bus.err, m_bus.rty, decerr_o, timeout_o}, 0);
        master_idle();
        next();
        rst_n = 1'b1;

        // Write to slave 0, acked two cycles after its strobe.
        next();
        master_start(32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
        sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        samp();
        check("t1_decode_stb", s0_bus.stb, 0);
        next();
        samp();
        check("t1_stb_rise", s0_bus.stb, 1);
        check("t1_adr", s0_bus.adr, 32'h0000_0010);
        check("t1_wdata", s0_bus.dat_w, 32'hDEAD_BEEF);
        check("t1_s1_idle", s1_bus.stb, 0);
        next();
        s1_bus.ack = 1'b1;
        samp();
        check("t1_foreign_ack", m_bus.ack, 0);
        next();
        s1_bus.ack = 1'b0;
        s0_bus.ack = 1'b1;
        samp();
        check("t1_ack_pass", m_bus.ack, 1);
        check("t1_s1_never", s1_bus.stb, 0);
        next();
        s0_bus.ack = 1'b0;
        master_idle();
        samp();
        check("t1_release", s0_bus.stb, 0);

        // Read from slave 1.
        next();
        master_start(32'h0001_0004, 1'b0, 32'h0);
        sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5678));
        next();
        samp();
        check("t2_s1_stb", s1_bus.stb, 1);
        check("t2_s0_idle", s0_bus.stb, 0);
        next();
        s1_bus.ack   = 1'b1;
        s1_bus.dat_r = 32'h1234_5678;
        samp();
        next();
        s1_bus.ack   = 1'b0;
        s1_bus.dat_r = 32'h0;
        samp();
        check("t2_back_idle", {s1_bus.stb, m_bus.ack}, 0);
        next();
        master_idle();
        next();
        samp();
        check("t2_abort_clean", s1_bus.cyc, 0);

        // Unmapped access.
        next();
        master_start(32'h0002_0000, 1'b0, 32'h0);
        sb_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0));
        samp();
        check("t3_not_yet", decerr_o, 0);
        next();
        samp();
        check("t3_no_stb", {s0_bus.stb, s1_bus.stb}, 0);
        next();
        master_idle();
        samp();
        check("t3_one_cycle", {m_bus.err, decerr_o}, 0);

        // Slave 0 never answers: timeout on the 8th ACTIVE cycle.
        next();
        master_start(32'h0000_0020, 1'b0, 32'h0);
        sb_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0));
        for (int k = 1; k <= 8; k++) begin
            next();
            samp();
            if (k < 8) check("t4_cyc_held", s0_bus.cyc, 1);
            else       check("t4_cyc_cut", s0_bus.cyc, 0);
        end
        next();
        master_idle();
        samp();
        check("t4_after", {s0_bus.cyc, timeout_o}, 0);

        // Ack lands on the same cycle the timeout would fire.
        next();
        master_start(32'h0000_0024, 1'b0, 32'h0);
        sb_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0));
        for (int k = 1; k <= 8; k++) begin
            next();
            if (k == 8) s0_bus.ack = 1'b1;
            samp();
        end
        check("t5_no_timeout", {m_bus.err, timeout_o}, 0);
        next();
        s0_bus.ack = 1'b0;
        master_idle();

        // Master drops cyc on the 3rd ACTIVE cycle while the slave acks.
        next();
        master_start(32'h0000_0030, 1'b0, 32'h0);
        next();
        samp();
        check("t6_active", s0_bus.cyc, 1);
        next();
        next();
        m_bus.cyc  = 1'b0;
        s0_bus.ack = 1'b1;
        samp();
        check("t6_cyc_gate", {s0_bus.cyc, s0_bus.stb}, 0);
        check("t6_no_ack", m_bus.ack, 0);
        next();
        s0_bus.ack = 1'b0;
        master_idle();

        // Asynchronous reset in the middle of a beat.
        next();
        master_start(32'h0000_0040, 1'b0, 32'h0);
        next();
        samp();
        check("t7_active", s0_bus.cyc, 1);
        #1;
        s0_bus.ack = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_rst_slave", {s0_bus.cyc, s0_bus.stb, s1_bus.cyc, s1_bus.stb}, 0);
        check("t7_rst_master", {m_bus.ack, m_bus.err, m_bus.rty, decerr_o, timeout_o}, 0);
        s0_bus.ack = 1'b0;
        master_idle();
        next();
        next();
        rst_n = 1'b1;
        next();

        check("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
